// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - raw button inputs and count/status outputs of the stopwatch core
// master drives the buttons and observes the count; slave is the stopwatch core.
interface stopwatch_counter_if;
  logic       btn_start_raw;
  logic       btn_clear_raw;
  logic [7:0] count;
  logic       running;
  logic       wrap_pulse;

  modport master (
    output btn_start_raw,
    output btn_clear_raw,
    input  count,
    input  running,
    input  wrap_pulse
  );

  modport slave (
    input  btn_start_raw,
    input  btn_clear_raw,
    output count,
    output running,
    output wrap_pulse
  );
endinterface

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - two-digit stopwatch core with debounced start/clear buttons
// IDLE/RUN/PAUSE machine advancing a 0..MAX_COUNT counter every TICK_DIV cycles while running.
module stopwatch_counter #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_COUNT       = 99
) (
  input  logic               clk,
  input  logic               rst_n,
  stopwatch_counter_if.slave sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    CNT_MAX    = 8'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Bit 0 is the start button, bit 1 the clear button throughout.
  logic [1:0]         raw;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         vld_q;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         armed_q, armed_d;
  logic [1:0]         press_q, press_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    count_q, count_d;
  logic          running_q, running_d;
  logic          wrap_q, wrap_d;
  logic          start_press, clear_press;

  assign raw         = {sw.btn_clear_raw, sw.btn_start_raw};
  assign start_press = press_q[0];
  assign clear_press = press_q[1];

  // A button only arms once a valid low sample is seen, so a button held
  // through reset release is accepted silently instead of as a press.
  always_comb begin
    lvl_d     = lvl_q;
    armed_d   = armed_q;
    press_d   = '0;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (vld_q[1] && !sync2_q[i]) begin
        armed_d[i] = 1'b1;
      end
      if (sync2_q[i] == lvl_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        lvl_d[i]     = sync2_q[i];
        press_d[i]   = sync2_q[i] & armed_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (count_q >= CNT_MAX) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + 8'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (start_press) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (start_press) state_d = S_RUN;
      end
      default: begin
        presc_d = '0;
        if (start_press) state_d = S_RUN;
      end
    endcase
    if (clear_press) begin
      state_d = S_IDLE;
      presc_d = '0;
      count_d = '0;
      wrap_d  = 1'b0;
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      vld_q     <= '0;
      lvl_q     <= '0;
      armed_q   <= '0;
      press_q   <= '0;
      deb_cnt_q <= '0;
      state_q   <= S_IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      vld_q     <= {vld_q[0], 1'b1};
      lvl_q     <= lvl_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign sw.count      = count_q;
  assign sw.running    = running_q;
  assign sw.wrap_pulse = wrap_q;

endmodule
